mash111_modulator: RTL and testbench

MASH111_MODULATOR -- requirements
Module: mash111_modulator

---
 rtl/mash_pkg.sv | 17 +
 rtl/mash_acc_stage.sv | 37 +++
 rtl/mash111_modulator.sv | 111 +++++++++++
 tb/tb_mash111_modulator.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mash_pkg.sv
// rtl/mash_pkg.sv - shared constants and helpers for the MASH 1-1-1 modulator
// Contents:
//   OUT_WIDTH         width of the signed modulator output
//   OUT_MIN, OUT_MAX  legal range of the MASH 1-1-1 output word
//   msb_offset()      offset that maps a signed sample onto an unsigned code
package mash_pkg;

  localparam int OUT_WIDTH = 4;
  localparam int OUT_MIN   = -3;
  localparam int OUT_MAX   = 4;

  // Adding 2^(width-1) modulo 2^width is the same as inverting the MSB.
  function automatic int msb_offset(input int width);
    return 1 << (width - 1);
  endfunction

endpackage

// File: rtl/mash_acc_stage.sv
// rtl/mash_acc_stage.sv - one modulo-2^WIDTH accumulator stage of the MASH chain
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          accumulator update enable
//   addend      value added to the accumulator this cycle
//   cin         carry-in to the addition
//   sum         combinational (acc + addend + cin) mod 2^WIDTH
//   carry       combinational carry-out of that addition
module mash_acc_stage
  import mash_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] addend,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] acc;

  // Sum and carry are combinational so the next stage can chain off them
  // in the same cycle.
  assign {carry, sum} = {1'b0, acc} + {1'b0, addend} + {{WIDTH{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/mash111_modulator.sv
// rtl/mash111_modulator.sv - third-order MASH 1-1-1 delta-sigma modulator
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   enable      global run gate
//   data_in     signed BIT_WIDTH sample from the CIC interpolator
//   in_valid    data_in qualifier
//   data_out    signed OUT_WIDTH output, range OUT_MIN..OUT_MAX
//   out_valid   high on the cycle after each accepted sample
// Build option: MASH_DITHER_EN adds a 15-bit LFSR dither on the first stage carry-in.
module mash111_modulator
  import mash_pkg::*;
#(
  parameter int BIT_WIDTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic signed [BIT_WIDTH-1:0] data_in,
  input  logic                        in_valid,
  output logic signed [OUT_WIDTH-1:0] data_out,
  output logic                        out_valid
);

  localparam logic [BIT_WIDTH-1:0] OFFSET = BIT_WIDTH'(msb_offset(BIT_WIDTH));

  logic                 accept;
  logic [BIT_WIDTH-1:0] u;
  logic                 dither;
  logic [BIT_WIDTH-1:0] s1, s2, s3_unused;
  logic                 c1, c2, c3;
  logic                 c2_d, c3_d, c3_dd;
  logic [OUT_WIDTH-1:0] mix;

  assign accept = enable & in_valid;
  assign u      = $unsigned(data_in) + OFFSET;

`ifdef MASH_DITHER_EN
  logic [14:0] lfsr;

  // x^15 + x^14 + 1, stepped only when a sample is consumed so the dither
  // sequence is tied to the sample stream rather than to wall-clock cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 15'h0001;
    end else if (accept) begin
      lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
    end
  end

  assign dither = lfsr[0];
`else
  assign dither = 1'b0;
`endif

  mash_acc_stage #(.WIDTH(BIT_WIDTH)) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .addend(u),
    .cin   (dither),
    .sum   (s1),
    .carry (c1)
  );

  mash_acc_stage #(.WIDTH(BIT_WIDTH)) u_stage2 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .addend(s1),
    .cin   (1'b0),
    .sum   (s2),
    .carry (c2)
  );

  // The last stage only contributes its carry; its sum lives on inside the stage.
  mash_acc_stage #(.WIDTH(BIT_WIDTH)) u_stage3 (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (accept),
    .addend(s2),
    .cin   (1'b0),
    .sum   (s3_unused),
    .carry (c3)
  );

  // Noise-cancellation network: c1 + (1-z^-1)c2 + (1-z^-1)^2 c3.
  // Evaluated modulo 2^OUT_WIDTH; the true result always fits OUT_MIN..OUT_MAX,
  // so the two's-complement reading of the low bits is exact.
  assign mix = OUT_WIDTH'(c1)
             + OUT_WIDTH'(c2) - OUT_WIDTH'(c2_d)
             + OUT_WIDTH'(c3) - OUT_WIDTH'({c3_d, 1'b0}) + OUT_WIDTH'(c3_dd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
      c2_d      <= 1'b0;
      c3_d      <= 1'b0;
      c3_dd     <= 1'b0;
    end else begin
      out_valid <= accept;
      if (accept) begin
        data_out <= signed'(mix);
        c2_d     <= c2;
        c3_d     <= c3;
        c3_dd    <= c3_d;
      end
    end
  end

endmodule

// File: tb/tb_mash111_modulator.sv
// tb/tb_mash111_modulator.sv - scoreboard testbench for mash111_modulator
module tb_mash111_modulator;
  import mash_pkg::*;

  typedef struct {
    logic signed [3:0] val;
    bit                chk_val;
    bit                sum_chk;
    int                lo;
    int                hi;
    string             tag;
    int                idx;
  } item_t;

  logic              clk      = 1'b0;
  logic              rst_n    = 1'b1;
  logic              enable   = 1'b0;
  logic              in_valid = 1'b0;
  logic signed [3:0] data_in  = '0;
  logic signed [3:0] data_out;
  logic              out_valid;

  item_t             sb[$];
  item_t             it;
  int                checks   = 0;
  int                failures = 0;
  bit                exp_ov   = 1'b0;
  int                sum      = 0;
  logic signed [3:0] last_out = '0;
  bit                done     = 1'b0;

  // Hand-derived reference sequences from an all-zero state.
  localparam logic signed [3:0] SEQ0 [4]  = '{4'sd0, 4'sd2, -4'sd1, 4'sd1};
  localparam logic signed [3:0] SEQ7 [16] = '{4'sd0, 4'sd3, 4'sd0, 4'sd0, 4'sd2, 4'sd1, 4'sd0, 4'sd2,
                                              4'sd0, 4'sd2, 4'sd0, 4'sd1, 4'sd1, 4'sd2, -4'sd1, 4'sd3};

  int cic_pat [8] = '{1, 1, -1, -1, 1, -1, 1, -1};
  int comb_d  [4] = '{0, 0, 0, 0};
  int integ   [4] = '{0, 0, 0, 0};
  int cx, cy;

  mash111_modulator #(.BIT_WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .data_in  (data_in),
    .in_valid (in_valid),
    .data_out (data_out),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_ov <= 1'b0;
    else        exp_ov <= enable && in_valid;
  end

  task automatic chk(input bit ok, input string name, input int act, input int lo, input int hi);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output.
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      #1;
      chk(data_out == 4'sd0, "reset_data_out", int'(data_out), 0, 0);
      chk(out_valid == 1'b0, "reset_out_valid", int'(out_valid), 0, 0);
      last_out = '0;
      sum      = 0;
    end else begin
      chk(out_valid == exp_ov, "out_valid_track", int'(out_valid), int'(exp_ov), int'(exp_ov));
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk(1'b0, "unexpected_output", int'(data_out), 0, 0);
        end else begin
          it = sb.pop_front();
          chk(!$isunknown(data_out), $sformatf("%s[%0d]_no_x", it.tag, it.idx), int'(data_out), 0, 0);
          chk(int'(data_out) >= OUT_MIN && int'(data_out) <= OUT_MAX,
              $sformatf("%s[%0d]_range", it.tag, it.idx), int'(data_out), OUT_MIN, OUT_MAX);
          if (it.chk_val)
            chk(data_out === it.val, $sformatf("%s[%0d]_value", it.tag, it.idx),
                int'(data_out), int'(it.val), int'(it.val));
          sum += int'(data_out);
          if (it.sum_chk) begin
            chk(sum >= it.lo && sum <= it.hi, $sformatf("%s_sum", it.tag), sum, it.lo, it.hi);
            sum = 0;
          end
        end
        last_out = data_out;
      end else begin
        chk(data_out === last_out, "gap_hold", int'(data_out), int'(last_out), int'(last_out));
      end
      if (done) begin
        chk(sb.size() == 0, "queue_drained", sb.size(), 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic send(input logic signed [3:0] d, input logic signed [3:0] v, input bit cv,
                      input bit sc, input int lo, input int hi, input string tag, input int idx);
    item_t t;
    @(negedge clk);
    data_in  = d;
    enable   = 1'b1;
    in_valid = 1'b1;
    t.val = v; t.chk_val = cv; t.sum_chk = sc; t.lo = lo; t.hi = hi; t.tag = tag; t.idx = idx;
    sb.push_back(t);
  endtask

  task automatic gap(input bit via_enable);
    @(negedge clk);
    data_in = -4'sd8;
    if (via_enable) begin
      enable   = 1'b0;
      in_valid = 1'b1;
    end else begin
      enable   = 1'b1;
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    enable   = 1'b1;
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #3 rst_n = 1'b1;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      send(-4'sd8, 4'sd0, 1'b1, i == 7, 0, 0, "neg8", i);

    for (int i = 0; i < 256; i++)
      send(4'sd0, SEQ0[i % 4], 1'b1, i == 255, 127, 130, "zero", i);

    for (int i = 0; i < 16; i++)
      send(4'sd7, SEQ7[i], 1'b1, i == 15, 14, 17, "pos7", i);

    pulse_reset();

    for (int i = 0; i < 16; i++) begin
      send(4'sd7, SEQ7[i], 1'b1, i == 15, 14, 17, "gaps", i);
      gap(i[0]);
    end

    pulse_reset();

    for (int n = 0; n < 8; n++) begin
      cx = cic_pat[n];
      for (int k = 0; k < 4; k++) begin
        cy        = cx - comb_d[k];
        comb_d[k] = cx;
        cx        = cy;
      end
      for (int p = 0; p < 4; p++) begin
        cy = (p == 0) ? cx : 0;
        for (int k = 0; k < 4; k++) begin
          integ[k] += cy;
          cy        = integ[k];
        end
        cy = cy >>> 4;
        if (cy > 7)  cy = 7;
        if (cy < -8) cy = -8;
        send(4'(cy), 4'sd0, 1'b0, 1'b0, 0, 0, "cic", n * 4 + p);
      end
    end

    gap(1'b0);
    gap(1'b0);
    @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
